// File: rtl/credit_traffic_source.sv
// Credit-flow-controlled packet generator: emits programmable bursts of
// multi-flit packets into one node input channel and reports progress.
module credit_traffic_source #(
    parameter int CHANNEL_WIDTH    = 48,
    parameter int FLITS_PER_PACKET = 4,
    parameter int BUFFER_DEPTH     = 4,
    parameter int X_WIDTH          = 4,
    parameter int Y_WIDTH          = 4,
    parameter int CNT_WIDTH        = 16,
    localparam int CC_W            = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_WIDTH-1:0]     num_packets,
    input  logic [CNT_WIDTH-1:0]     gap_cycles,
    input  logic [X_WIDTH-1:0]       dest_x,
    input  logic [Y_WIDTH-1:0]       dest_y,
    input  logic                     credit_in,
    output logic [CHANNEL_WIDTH-1:0] channel_out,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_WIDTH-1:0]     packets_sent,
    output logic [CC_W-1:0]          credit_count
);

    localparam int PW   = CHANNEL_WIDTH - 3;
    localparam int FI_W = (FLITS_PER_PACKET > 2) ? $clog2(FLITS_PER_PACKET) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t               state;
    logic [FI_W-1:0]      flit_idx;
    logic [CNT_WIDTH-1:0] gap_cnt;
    logic [CNT_WIDTH-1:0] cfg_num;
    logic [CNT_WIDTH-1:0] cfg_gap;
    logic [X_WIDTH-1:0]   cfg_x;
    logic [Y_WIDTH-1:0]   cfg_y;

    logic                 can_send;
    logic                 is_head;
    logic                 is_tail;
    logic [PW-1:0]        payload;
    logic [7:0]           pk8;
    logic [7:0]           fi8;

    // A returning credit in the same cycle lets us send even at zero credits.
    assign can_send = (state == SEND) && ((credit_count != '0) || credit_in);
    assign is_head  = (flit_idx == '0);
    assign is_tail  = (flit_idx == FI_W'(FLITS_PER_PACKET - 1));
    assign pk8      = 8'(packets_sent);
    assign fi8      = 8'(flit_idx);

    always_comb begin
        payload = PW'({pk8, fi8});
        if (is_head)
            payload = PW'({packets_sent, cfg_x, cfg_y});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            channel_out  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            packets_sent <= '0;
            credit_count <= CC_W'(BUFFER_DEPTH);
            flit_idx     <= '0;
            gap_cnt      <= '0;
            cfg_num      <= '0;
            cfg_gap      <= '0;
            cfg_x        <= '0;
            cfg_y        <= '0;
        end else begin
            channel_out <= '0;

            if (can_send && !credit_in)
                credit_count <= credit_count - 1'b1;
            else if (!can_send && credit_in && credit_count != CC_W'(BUFFER_DEPTH))
                credit_count <= credit_count + 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cfg_num      <= num_packets;
                        cfg_gap      <= gap_cycles;
                        cfg_x        <= dest_x;
                        cfg_y        <= dest_y;
                        packets_sent <= '0;
                        flit_idx     <= '0;
                        if (num_packets == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= SEND;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (can_send) begin
                        channel_out <= {1'b1, is_head, is_tail, payload};
                        if (is_tail) begin
                            flit_idx     <= '0;
                            packets_sent <= packets_sent + 1'b1;
                            if (packets_sent + 1'b1 == cfg_num) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else if (cfg_gap != '0) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            flit_idx <= flit_idx + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == cfg_gap - 1'b1)
                        state <= SEND;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
